// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared types and encodings for the multicycle RV32I-subset control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_t       : controller state, 4-bit encoding exported on the debug port
//   OP_*          : opcodes the controller recognises
//   ALU_*         : alu_control codes seen by the ALU
//   ALUOP_*       : coarse ALU request from the FSM to the ALU decoder
//   RES_/SRCA_/SRCB_/IMM_* : datapath mux encodings
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation codes driven to the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Coarse ALU request from the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of state.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose: map the FSM's coarse ALU request plus funct fields to an ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//   alu_op      in  2  ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], distinguishes R-type from I-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // instr[30] only means sub for register-register ops; for addi
          // it is just an immediate bit.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: control FSM sequencing the multicycle RV32I-subset datapath, with instret counter.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles when memory answers at once.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready=0; each wait cycle adds one.
//   clk, rst         clock (rising) and asynchronous active-low reset
//   op/funct3/funct7b5  instruction fields from the IR; zero from the ALU
//   mem_ready        memory completed the current access
//   mem_req/adr_src/mem_write  memory interface control
//   ir_write/pc_write/reg_write  architectural state write enables
//   result_src/alu_src_a/alu_src_b/alu_control/imm_src  datapath selects
//   halted           high while trapped; instret retired count; state debug
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_BITS        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_control,
  output logic [1:0]          imm_src,
  output logic                halted,
  output logic [CNT_BITS-1:0] instret,
  output logic [3:0]          state
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] instret_q;

  // Raw (pre-reset-gating) decodes
  logic       mem_req_m, mem_write_m, ir_write_m, reg_write_m;
  logic       pc_update, branch, retire;
  logic [1:0] alu_op;

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + CNT_ONE;
      end
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    mem_req_m   = 1'b0;
    adr_src     = 1'b0;
    mem_write_m = 1'b0;
    ir_write_m  = 1'b0;
    reg_write_m = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    retire      = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALUOP_ADD;

    unique case (state_q)
      FETCH: begin
        // PC+4 is computed while the instruction is read; both the IR and
        // the PC are loaded on the cycle memory returns the word.
        mem_req_m  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_m = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        // OldPC + imm: the branch target is ready in ALUOut for BEQ.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = TRAP;
            end else begin
              state_d = FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end

      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        mem_req_m = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end
      end

      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_m = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end

      MEMWRITE: begin
        // Write strobe stays up through the accepting cycle.
        mem_req_m   = 1'b1;
        adr_src     = 1'b1;
        mem_write_m = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end

      EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end

      EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end

      ALUWB: begin
        reg_write_m = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end

      BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC+4
        // for the link register; ALUWB then retires the instruction.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Strobes are killed combinationally so an asserted reset silences the
  // datapath in the same cycle, even while FETCH would echo mem_ready.
  assign mem_req   = rst & mem_req_m;
  assign mem_write = rst & mem_write_m;
  assign ir_write  = rst & ir_write_m;
  assign reg_write = rst & reg_write_m;
  assign pc_write  = rst & (pc_update | (branch & zero));

  assign imm_src = imm_decode(op);
  assign halted  = (state_q == TRAP);
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  localparam int D = -1;  // field not checked in this row
  localparam logic [6:0] C_LW  = 7'b0000011;
  localparam logic [6:0] C_SW  = 7'b0100011;
  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_BEQ = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;
  localparam logic [6:0] C_ILL = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;

  logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, halted;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;
  logic [3:0]  state;

  logic        mem_req2, adr_src2, mem_write2, ir_write2, pc_write2, reg_write2, halted2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, imm_src2;
  logic [2:0]  alu_control2;
  logic [3:0]  instret2;
  logic [3:0]  state2;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1), .CNT_BITS(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .halted(halted), .instret(instret), .state(state)
  );

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0), .CNT_BITS(4)) dut_nop (
    .clk(clk), .rst(rst2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req2), .adr_src(adr_src2),
    .mem_write(mem_write2), .ir_write(ir_write2), .pc_write(pc_write2),
    .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_control(alu_control2), .imm_src(imm_src2),
    .halted(halted2), .instret(instret2), .state(state2)
  );

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;
    int         st;
    logic [4:0] stb;  // {mem_req, mem_write, ir_write, pc_write, reg_write}
    int         adr, rs, sa, sb, ac, imm, h, ir;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, int idx, int act, int exp);
    if (exp < 0) return;
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input int st,
                     input logic [4:0] stb, input int adr, input int rs, input int sa,
                     input int sb, input int ac, input int imm, input int h, input int ir);
    vec_t v;
    v.r = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.st = st; v.stb = stb; v.adr = adr; v.rs = rs; v.sa = sa; v.sb = sb;
    v.ac = ac; v.imm = imm; v.h = h; v.ir = ir;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst2 = 1'b0; op = C_R; funct3 = 3'b000; funct7b5 = 1'b1;
    zero = 1'b0; mem_ready = 1'b1;

    //   r  op    f3 f7 z rdy state     strobes   adr rs sa sb ac imm h ir
    add(0, C_R,   0, 1, 0, 1, FETCH,    5'b00000, 0, 2, 0, 2, 0, 0, 0, 0);
    // sub: FETCH, DECODE, EXECR, ALUWB
    add(1, C_R,   0, 1, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 0);
    add(1, C_R,   0, 1, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 0);
    add(1, C_R,   0, 1, 0, 1, EXECR,    5'b00000, D, D, 2, 0, 1, 0, 0, 0);
    add(1, C_R,   0, 1, 0, 1, ALUWB,    5'b00001, D, 0, D, D, D, 0, 0, 0);
    // lw: FETCH 3 cycles, MEMREAD 4 cycles
    add(1, C_LW,  2, 0, 0, 0, FETCH,    5'b10000, 0, 2, 0, 2, 0, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 0, FETCH,    5'b10000, 0, 2, 0, 2, 0, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 1, MEMADR,   5'b00000, D, D, 2, 1, 0, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 0, MEMREAD,  5'b10000, 1, 0, D, D, D, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 0, MEMREAD,  5'b10000, 1, 0, D, D, D, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 0, MEMREAD,  5'b10000, 1, 0, D, D, D, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 1, MEMREAD,  5'b10000, 1, 0, D, D, D, 0, 0, 1);
    add(1, C_LW,  2, 0, 0, 1, MEMWB,    5'b00001, D, 1, D, D, D, 0, 0, 1);
    // sw
    add(1, C_SW,  2, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 1, 0, 2);
    add(1, C_SW,  2, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 1, 0, 2);
    add(1, C_SW,  2, 0, 0, 1, MEMADR,   5'b00000, D, D, 2, 1, 0, 1, 0, 2);
    add(1, C_SW,  2, 0, 0, 1, MEMWRITE, 5'b11000, 1, 0, D, D, D, 1, 0, 2);
    // beq taken, then not taken
    add(1, C_BEQ, 0, 0, 1, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 2, 0, 3);
    add(1, C_BEQ, 0, 0, 1, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 2, 0, 3);
    add(1, C_BEQ, 0, 0, 1, 1, BEQ,      5'b00010, D, 0, 2, 0, 1, 2, 0, 3);
    add(1, C_BEQ, 0, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 2, 0, 4);
    add(1, C_BEQ, 0, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 2, 0, 4);
    add(1, C_BEQ, 0, 0, 0, 1, BEQ,      5'b00000, D, 0, 2, 0, 1, 2, 0, 4);
    // jal
    add(1, C_JAL, 0, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 3, 0, 5);
    add(1, C_JAL, 0, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 3, 0, 5);
    add(1, C_JAL, 0, 0, 0, 1, JAL,      5'b00010, D, 0, 1, 2, 0, 3, 0, 5);
    add(1, C_JAL, 0, 0, 0, 1, ALUWB,    5'b00001, D, 0, D, D, D, 3, 0, 5);
    // addi with instr[30]=1 must still add
    add(1, C_I,   0, 1, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 6);
    add(1, C_I,   0, 1, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 6);
    add(1, C_I,   0, 1, 0, 1, EXECI,    5'b00000, D, D, 2, 1, 0, 0, 0, 6);
    add(1, C_I,   0, 1, 0, 1, ALUWB,    5'b00001, D, 0, D, D, D, 0, 0, 6);
    // and (R-type funct3=111)
    add(1, C_R,   7, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 7);
    add(1, C_R,   7, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 7);
    add(1, C_R,   7, 0, 0, 1, EXECR,    5'b00000, D, D, 2, 0, 2, 0, 0, 7);
    add(1, C_R,   7, 0, 0, 1, ALUWB,    5'b00001, D, 0, D, D, D, 0, 0, 7);
    // slti
    add(1, C_I,   2, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 8);
    add(1, C_I,   2, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 8);
    add(1, C_I,   2, 0, 0, 1, EXECI,    5'b00000, D, D, 2, 1, 5, 0, 0, 8);
    add(1, C_I,   2, 0, 0, 1, ALUWB,    5'b00001, D, 0, D, D, D, 0, 0, 8);
    // illegal op traps and stays trapped
    add(1, C_ILL, 0, 0, 0, 1, FETCH,    5'b10110, 0, 2, 0, 2, 0, 0, 0, 9);
    add(1, C_ILL, 0, 0, 0, 1, DECODE,   5'b00000, D, D, 1, 1, 0, 0, 0, 9);
    add(1, C_ILL, 0, 0, 0, 1, TRAP,     5'b00000, D, D, D, D, D, 0, 1, 9);
    add(1, C_ILL, 0, 0, 0, 1, TRAP,     5'b00000, D, D, D, D, D, 0, 1, 9);
    add(1, C_LW,  2, 0, 0, 1, TRAP,     5'b00000, D, D, D, D, D, 0, 1, 9);
    // reset clears the trap
    add(0, C_LW,  2, 0, 0, 1, FETCH,    5'b00000, 0, 2, 0, 2, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
      zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      chk("state",       i, int'(state),       tbl[i].st);
      chk("mem_req",     i, int'(mem_req),     int'(tbl[i].stb[4]));
      chk("mem_write",   i, int'(mem_write),   int'(tbl[i].stb[3]));
      chk("ir_write",    i, int'(ir_write),    int'(tbl[i].stb[2]));
      chk("pc_write",    i, int'(pc_write),    int'(tbl[i].stb[1]));
      chk("reg_write",   i, int'(reg_write),   int'(tbl[i].stb[0]));
      chk("adr_src",     i, int'(adr_src),     tbl[i].adr);
      chk("result_src",  i, int'(result_src),  tbl[i].rs);
      chk("alu_src_a",   i, int'(alu_src_a),   tbl[i].sa);
      chk("alu_src_b",   i, int'(alu_src_b),   tbl[i].sb);
      chk("alu_control", i, int'(alu_control), tbl[i].ac);
      chk("imm_src",     i, int'(imm_src),     tbl[i].imm);
      chk("halted",      i, int'(halted),      tbl[i].h);
      chk("instret",     i, int'(instret),     tbl[i].ir);
    end

    // sw stalled in MEMWRITE, then reset asserted mid-cycle
    @(negedge clk);
    rst = 1'b1; op = C_SW; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("abort_state",     100, int'(state),     int'(MEMWRITE));
    chk("abort_mem_write", 100, int'(mem_write), 1);
    @(negedge clk);
    #1;
    chk("stall_state",     101, int'(state),     int'(MEMWRITE));
    chk("stall_mem_write", 101, int'(mem_write), 1);
    chk("stall_instret",   101, int'(instret),   0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state",     102, int'(state),     int'(FETCH));
    chk("abort_mem_write", 102, int'(mem_write), 0);
    chk("abort_mem_req",   102, int'(mem_req),   0);
    chk("abort_ir_write",  102, int'(ir_write),  0);
    chk("abort_pc_write",  102, int'(pc_write),  0);
    chk("abort_instret",   102, int'(instret),   0);

    // Illegal ops retired as NOPs on a 4-bit counter wrap after 16
    @(negedge clk);
    rst2 = 1'b1; op = C_ILL; funct3 = 3'b000; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("nop_fetch_state", 200 + k, int'(state2),   int'(FETCH));
      chk("nop_instret",     200 + k, int'(instret2), k);
      @(negedge clk);
      #1;
      chk("nop_decode_state", 200 + k, int'(state2),  int'(DECODE));
      chk("nop_halted",       200 + k, int'(halted2), 0);
      @(negedge clk);
    end
    #1;
    chk("wrap_instret", 300, int'(instret2), 0);
    chk("wrap_state",   300, int'(state2),   int'(FETCH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM that sequences the multicycle RV32I-subset datapath: program counter, register file, ALU and the shared instruction/data memory. It decodes op, funct3 and funct7[5] from the instruction register, and drives the mux selects and write strobes cycle by cycle. It stalls on a memory ready handshake and counts retired instructions. The datapath top instantiates it next to ProgramCounter.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP and halts; 0: it is retired as a NOP
CNT_BITS, 32, width of the instret counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result==0
mem_ready  in  1  memory has completed the current access
mem_req  out  1  memory access in progress
adr_src  out  1  0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  latch the instruction register
pc_write  out  1  PC load enable
reg_write  out  1  register file write
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rd1
alu_src_b  out  2  00 = rd2, 01 = ImmExt, 10 = const 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J
halted  out  1  sticky, high while in TRAP
instret  out  CNT_BITS  count of retired instructions
state  out  4  current state, for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Outputs are Moore decodes of the state, except pc_write.
- pc_write = pc_update | (branch & zero).
- imm_src is a combinational decode of op: lw/I-type 00, sw 01, beq 10, jal 11, anything else 00.
- Reset: while rst=0, state=FETCH, instret=0, halted=0. mem_req, ir_write, pc_write, mem_write and reg_write are forced to 0; the selects take their FETCH values.
- FETCH: mem_req=1, adr_src=0, srcA=00, srcB=10, alu_op=add, result_src=10. ir_write and pc_update equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: srcA=01, srcB=01, add (computes the branch target).
- DECODE next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> TRAP if TRAP_ON_ILLEGAL=1, else FETCH with a retire
- MEMADR: srcA=10, srcB=01, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00. mem_write is held high until the mem_ready cycle inclusive; then retire and go to FETCH.
- EXECR: srcA=10, srcB=00, alu_op=funct, then ALUWB.
- EXECI: srcA=10, srcB=01, alu_op=funct, then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire, then FETCH.
- BEQ: srcA=10, srcB=00, sub, result_src=00, branch=1, retire, then FETCH.
- JAL: srcA=01, srcB=10, add, result_src=00, pc_update=1, then ALUWB.
- ALU decode for alu_op=funct:
  - funct3 000: sub when op[5]&funct7b5, else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - any other funct3: add
- TRAP: all strobes 0, mem_req=0, halted=1. TRAP is left only through reset.
- Retire: instret increments by 1 on the clock edge that leaves the retiring state. It wraps modulo 2^CNT_BITS.
- Cycle counts with mem_ready=1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds one.
- Reset asserted mid-instruction aborts the instruction at once; no strobe stays high after rst falls.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum (4 bits)
  - opcode constants
  - alu_control codes
  - alu_op codes (add, sub, funct)
  - encodings for result_src, alu_src_a, alu_src_b and imm_src
- Sub-module alu_decoder: combinational, inputs alu_op, funct3, op[5] and funct7b5, output alu_control.

Test Plan:
- Reset, then rst=1 with mem_ready=1 and op=0110011, funct3=000, funct7b5=1 -> states FETCH, DECODE, EXECR, ALUWB. Expect alu_control=001 in EXECR, reg_write=1 in ALUWB, instret=1 after 4 cycles.
- lw (op 0000011) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> FETCH lasts 3 cycles and MEMREAD 4. ir_write is a 1-cycle pulse. reg_write=1 with result_src=01 in MEMWB. Total 10 cycles.
- sw (op 0100011) with mem_ready=1 -> mem_write=1 for exactly 1 cycle, adr_src=1, imm_src=01.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in BEQ for the first and 0 for the second. instret is +1 for each.
- jal -> pc_write=1 in JAL, reg_write=1 in ALUWB, imm_src=11.
- op=1111111: with TRAP_ON_ILLEGAL=1 -> halted=1 permanently and all strobes 0; then rst=0 -> FETCH, halted=0, instret=0. With TRAP_ON_ILLEGAL=0 and CNT_BITS=4, 16 illegal ops -> instret wraps to 0.
